// File: rtl/nibble_serial_adder_ctrl.sv
// Serial WIDTH-bit adder sequencer driving one external 4-bit adder, LSB nibble first.
// Optional signed-overflow output enabled by defining NSA_OVF_EN.
module nibble_serial_adder_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [3:0]       fa_a_o,
  output logic [3:0]       fa_b_o,
  output logic             fa_cin_o,
  input  logic [3:0]       fa_sum_i,
  input  logic             fa_cout_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
`ifdef NSA_OVF_EN
  ,
  output logic             ovf_o
`endif
);

  localparam int unsigned NIBBLES = WIDTH / 4;
  localparam int unsigned IdxW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_bad_width
    $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             accept;
  logic             last_nib;
`ifdef NSA_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  assign accept   = in_valid_i && in_ready_o;
  assign last_nib = (idx_q == LastIdx);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef NSA_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef NSA_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StRun;
      StRun:   if (last_nib) state_d = StDone;
      StDone:  if (out_ready_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: capture on accept, then one nibble per RUN cycle.
  always_comb begin
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef NSA_OVF_EN
    ovf_d   = ovf_q;
`endif
    if (state_q == StIdle && accept) begin
      a_d     = a_i;
      b_d     = b_i;
      carry_d = cin_i;
      idx_d   = '0;
    end else if (state_q == StRun) begin
      sum_d[{idx_q, 2'b00} +: 4] = fa_sum_i;
      carry_d = fa_cout_i;
      idx_d   = last_nib ? '0 : idx_q + 1'b1;
      if (last_nib) begin
        cout_d = fa_cout_i;
`ifdef NSA_OVF_EN
        ovf_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (fa_sum_i[3] != a_q[WIDTH-1]);
`endif
      end
    end
  end

  always_comb begin
    in_ready_o  = (state_q == StIdle) && !rst_i;
    out_valid_o = (state_q == StDone);
    fa_a_o      = 4'h0;
    fa_b_o      = 4'h0;
    fa_cin_o    = 1'b0;
    if (state_q == StRun) begin
      fa_a_o   = a_q[{idx_q, 2'b00} +: 4];
      fa_b_o   = b_q[{idx_q, 2'b00} +: 4];
      fa_cin_o = carry_q;
    end
  end

  assign sum_o  = sum_q;
  assign cout_o = cout_q;
`ifdef NSA_OVF_EN
  assign ovf_o  = ovf_q;
`endif

endmodule
